// File: rtl/jkiss_arb_pkg.sv
// jkiss_arb_pkg: shared types and constants for the jkiss RNG arbiter.
//   arb_state_e : arbiter FSM state (WARM / SERVE / PULSE), 2-bit
//   WORD_W      : random word width
//   WARMUP_DEF  : default number of discarded warm-up words
package jkiss_arb_pkg;

  localparam int WORD_W     = 32;
  localparam int WARMUP_DEF = 2;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    SERVE = 2'd1,
    PULSE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jkiss_rr_pick.sv
// jkiss_rr_pick: combinational round-robin picker.
// Searches req upward starting at ptr, wrapping from N-1 to 0.
//   req    in  N      request vector
//   ptr    in  PTR_W  search start index
//   onehot out N      one-hot winner (0 when no request)
//   idx    out PTR_W  winner index (0 when no request)
//   any    out 1      at least one request present
module jkiss_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    any    = |req;
    for (int k = 0; k < N; k++) begin
      // ptr + k, folded back into 0..N-1 (works for non power-of-two N)
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/jkiss_arbiter.sv
// jkiss_arbiter: shares one jkiss RNG between N requesters and sequences
// reseeding (seed latch, one-cycle re_seed pulse, warm-up discard).
//   clk, rst     clock, synchronous active-high reset
//   req/gnt      per-requester level request / registered one-hot grant
//   rnd_out      registered random word, valid while gnt != 0
//   reseed_req/reseed_seed/reseed_ack  reseed handshake
//   busy         high outside SERVE
//   rng_seed/rng_re_seed/rng_rnd       connection to the jkiss core
// Optional build macro JKISS_ARB_STATS_EN adds grant_cnt and discard_cnt.
//
// state | meaning
// WARM  | discarding warm-up words, no grants
// SERVE | granting random words round-robin
// PULSE | one-cycle re_seed / ack pulse after reseed accept
module jkiss_arbiter
  import jkiss_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int WARMUP = WARMUP_DEF,
  parameter int PTR_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  output logic [N-1:0]      gnt,
  output logic [WORD_W-1:0] rnd_out,
  input  logic              reseed_req,
  input  logic [WORD_W-1:0] reseed_seed,
  output logic              reseed_ack,
  output logic              busy,
  output logic [WORD_W-1:0] rng_seed,
  output logic              rng_re_seed,
  input  logic [WORD_W-1:0] rng_rnd
`ifdef JKISS_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt,
  output logic [15:0]       discard_cnt
`endif
);

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  arb_state_e        state, state_nxt;
  logic [7:0]        warm_cnt, warm_cnt_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [N-1:0]      gnt_nxt;
  logic [WORD_W-1:0] rnd_nxt, seed_nxt;
  logic              pulse_q, pulse_nxt;

  logic [N-1:0]      pick_onehot;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  jkiss_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    ptr_nxt      = ptr;
    gnt_nxt      = '0;
    rnd_nxt      = rnd_out;
    seed_nxt     = rng_seed;
    pulse_nxt    = 1'b0;
    case (state)
      WARM: begin
        if (reseed_req) begin
          state_nxt    = PULSE;
          seed_nxt     = reseed_seed;
          pulse_nxt    = 1'b1;
          warm_cnt_nxt = WARM_INIT;
        end else begin
          // WARM lasts WARMUP cycles (one cycle when WARMUP is 0)
          if (warm_cnt <= 8'd1) state_nxt = SERVE;
          if (warm_cnt != 8'd0) warm_cnt_nxt = warm_cnt - 8'd1;
        end
      end
      SERVE: begin
        if (reseed_req) begin
          state_nxt    = PULSE;
          seed_nxt     = reseed_seed;
          pulse_nxt    = 1'b1;
          warm_cnt_nxt = WARM_INIT;
        end else if (pick_any) begin
          gnt_nxt = pick_onehot;
          rnd_nxt = rng_rnd;
          ptr_nxt = (pick_idx == PTR_W'(N-1)) ? '0 : pick_idx + PTR_W'(1);
        end
      end
      PULSE: state_nxt = WARM;
      default: state_nxt = WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARM;
      warm_cnt <= WARM_INIT;
      ptr      <= '0;
      gnt      <= '0;
      rnd_out  <= '0;
      rng_seed <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      rnd_out  <= rnd_nxt;
      rng_seed <= seed_nxt;
      pulse_q  <= pulse_nxt;
    end
  end

  // ack and re_seed are the same pulse by construction
  assign reseed_ack  = pulse_q;
  assign rng_re_seed = pulse_q;
  assign busy        = (state != SERVE);

`ifdef JKISS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (gnt_nxt != '0) grant_cnt <= grant_cnt + 32'd1;
      if (state == WARM && discard_cnt != 16'hFFFF) discard_cnt <= discard_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jkiss_arbiter.sv
// tb_jkiss_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the arbiter.
module tb_jkiss_arbiter;

  localparam int N      = 4;
  localparam int WARMUP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, gnt;
  logic [31:0]   rnd_out, reseed_seed, rng_seed, rng_rnd;
  logic          reseed_req, reseed_ack, busy, rng_re_seed;
`ifdef JKISS_ARB_STATS_EN
  logic [31:0]   grant_cnt;
  logic [15:0]   discard_cnt;
`endif

  always #5 clk = ~clk;

  jkiss_arbiter #(.N(N), .WARMUP(WARMUP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .rnd_out     (rnd_out),
    .reseed_req  (reseed_req),
    .reseed_seed (reseed_seed),
    .reseed_ack  (reseed_ack),
    .busy        (busy),
    .rng_seed    (rng_seed),
    .rng_re_seed (rng_re_seed),
    .rng_rnd     (rng_rnd)
`ifdef JKISS_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .discard_cnt (discard_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending pulse flag plus number of warm-up cycles still to run;
  // the arbiter serves only when neither is outstanding.
  bit          m_pulse;
  int          m_left;
  int          m_ptr;
  logic [N-1:0] m_gnt;
  logic [31:0] m_rnd, m_seed, m_gcnt;
  int          m_dcnt;

  function automatic int warm_len();
    return (WARMUP == 0) ? 1 : WARMUP;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_pulse = 0; m_left = warm_len(); m_ptr = 0; m_gnt = '0;
      m_rnd = 0; m_seed = 0; m_gcnt = 0; m_dcnt = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
      m_gnt   = '0;
    end else if (reseed_req) begin
      if (m_left > 0 && m_dcnt < 65535) m_dcnt++;
      m_pulse = 1;
      m_seed  = reseed_seed;
      m_left  = warm_len();
      m_gnt   = '0;
    end else if (m_left > 0) begin
      if (m_dcnt < 65535) m_dcnt++;
      m_left--;
      m_gnt = '0;
    end else if (req != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_gnt    = '0;
      m_gnt[w] = 1'b1;
      m_rnd    = rng_rnd;
      m_ptr    = (w + 1) % N;
      m_gcnt++;
    end else begin
      m_gnt = '0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("gnt",         32'(gnt),         32'(m_gnt));
    chk("rnd_out",     rnd_out,          m_rnd);
    chk("reseed_ack",  32'(reseed_ack),  32'(m_pulse));
    chk("rng_re_seed", 32'(rng_re_seed), 32'(m_pulse));
    chk("rng_seed",    rng_seed,         m_seed);
    chk("busy",        32'(busy),        32'(m_pulse || m_left > 0));
`ifdef JKISS_ARB_STATS_EN
    chk("grant_cnt",   grant_cnt,        m_gcnt);
    chk("discard_cnt", 32'(discard_cnt), 32'(m_dcnt));
`endif
  endtask

  task automatic step(input logic r, input logic [N-1:0] q, input logic rr, input logic [31:0] sd);
    rst = r; req = q; reseed_req = rr; reseed_seed = sd;
    @(posedge clk);
    model_edge();
    #1;
    rng_rnd = rng_rnd + 32'd1;
    compare_all();
  endtask

  logic [3:0]  exp_s1[5];
  logic [3:0]  exp_s2[3];
  logic [31:0] rv[5];
  logic [31:0] held;
  bit          rr_hold;
  logic [31:0] rr_seed;

  initial begin
    rst = 1'b1; req = '0; reseed_req = 1'b0; reseed_seed = '0; rng_rnd = 32'h0000_1000;
    exp_s1[0] = 4'b0001; exp_s1[1] = 4'b0010; exp_s1[2] = 4'b0100;
    exp_s1[3] = 4'b1000; exp_s1[4] = 4'b0001;
    exp_s2[0] = 4'b0010; exp_s2[1] = 4'b1000; exp_s2[2] = 4'b0010;

    // 1: reset, then all requesting
    step(1, '0, 0, 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rnd", rnd_out, 0);
    step(0, 4'hF, 0, 0);
    chk("s1_warm1_gnt", 32'(gnt), 0);
    chk("s1_warm1_busy", 32'(busy), 1);
    step(0, 4'hF, 0, 0);
    chk("s1_warm2_gnt", 32'(gnt), 0);
    chk("s1_serve_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hF, 0, 0);
      chk("s1_gnt", 32'(gnt), 32'(exp_s1[i]));
      rv[i] = rnd_out;
      if (i > 0) chk("s1_consec", rnd_out, rv[i-1] + 32'd1);
    end
`ifdef JKISS_ARB_STATS_EN
    chk("s6_grant_cnt", grant_cnt, 32'd5);
    chk("s6_discard_cnt", 32'(discard_cnt), 32'd2);
`endif

    // 2: sparse request, then idle
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1010, 0, 0);
      chk("s2_gnt", 32'(gnt), 32'(exp_s2[i]));
    end
    held = rnd_out;
    step(0, 4'b0000, 0, 0);
    chk("s2_idle_gnt", 32'(gnt), 0);
    chk("s2_hold_rnd", rnd_out, held);

    // 3: reseed from SERVE
    step(0, 4'hF, 1, 32'hDEADBEEF);
    chk("s3_re_seed", 32'(rng_re_seed), 1);
    chk("s3_ack", 32'(reseed_ack), 1);
    chk("s3_seed", rng_seed, 32'hDEADBEEF);
    chk("s3_nogrant", 32'(gnt), 0);
    step(0, 4'hF, 0, 0);
    chk("s3_re_seed_off", 32'(rng_re_seed), 0);
    chk("s3_ack_off", 32'(reseed_ack), 0);
    step(0, 4'hF, 0, 0);
    chk("s3_warm_gnt", 32'(gnt), 0);
    step(0, 4'hF, 0, 0);
    chk("s3_warm_gnt2", 32'(gnt), 0);
    step(0, 4'hF, 0, 0);
    chk("s3_resume_gnt", 32'(gnt), 32'(4'b0100));
    chk("s3_seed_hold", rng_seed, 32'hDEADBEEF);

    // 4: reseed during the second WARM cycle
    step(0, 4'hF, 1, 32'h1234_5678);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 1, 32'hCAFEBABE);
    chk("s4_ack", 32'(reseed_ack), 1);
    chk("s4_seed", rng_seed, 32'hCAFEBABE);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 0, 0);
    chk("s4_reload_busy", 32'(busy), 1);
    step(0, 4'hF, 0, 0);
    chk("s4_serve_busy", 32'(busy), 0);
    step(0, 4'hF, 0, 0);
    chk("s4_gnt", 32'(gnt), 32'(4'b1000));

    // 5: reset during PULSE
    step(0, 4'hF, 1, 32'h55AA_55AA);
    step(1, 4'hF, 0, 0);
    chk("s5_re_seed", 32'(rng_re_seed), 0);
    chk("s5_ack", 32'(reseed_ack), 0);
    chk("s5_gnt", 32'(gnt), 0);
    chk("s5_busy", 32'(busy), 1);
    step(0, 4'hF, 0, 0);
    chk("s5_warm_busy", 32'(busy), 1);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 0, 0);
    chk("s5_ptr0_gnt", 32'(gnt), 32'(4'b0001));

    // randomized traffic
    rr_hold = 0; rr_seed = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!rr_hold && $urandom_range(0, 30) == 0) begin
        rr_hold = 1;
        rr_seed = $urandom;
      end
      step(($urandom_range(0, 400) == 0), N'($urandom), rr_hold, rr_seed);
      // requester normally drops on ack; sometimes holds to force a re-reseed
      if (m_pulse) rr_hold = ($urandom_range(0, 3) == 0);
      if (rst) rr_hold = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
